// File: rtl/cmos_reg_cfg_ctrl_pkg.sv
// Shared types and constants for the camera register configuration sequencer.
// A table entry is {reg_addr[23:8], reg_val[7:0]}. An address of DELAY_MARKER
// turns the entry into a pause of reg_val delay units.
package cmos_cfg_pkg;

    localparam int ENTRY_W  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 8;
    localparam int VAL_MSB  = 7;
    localparam int VAL_LSB  = 0;

    localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

    typedef enum logic [3:0] {
        PWR_WAIT,
        FETCH_ADDR,
        FETCH_DATA,
        ISSUE,
        WAIT_DONE,
        GAP,
        DELAY,
        DONE,
        ERROR
    } cfgState_e;

    function automatic logic [15:0] entryAddr(input logic [ENTRY_W-1:0] entry);
        return entry[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [7:0] entryVal(input logic [ENTRY_W-1:0] entry);
        return entry[VAL_MSB:VAL_LSB];
    endfunction

endpackage

// File: rtl/cmos_reg_cfg_ctrl_if.sv
// Bus bundle between the sequencer, the register-table ROM and the SCCB driver.
// The master side is the sequencer: it addresses the ROM and launches writes.
interface cmos_reg_cfg_ctrl_if;
    import cmos_cfg_pkg::*;

    logic [7:0]         tbl_addr;
    logic [ENTRY_W-1:0] tbl_data;
    logic               i2c_exec;
    logic [15:0]        i2c_addr;
    logic [7:0]         i2c_wdata;
    logic               i2c_done;
    logic               i2c_ack_err;

    modport master (
        output tbl_addr, i2c_exec, i2c_addr, i2c_wdata,
        input  tbl_data, i2c_done, i2c_ack_err
    );

    modport slave (
        input  tbl_addr, i2c_exec, i2c_addr, i2c_wdata,
        output tbl_data, i2c_done, i2c_ack_err
    );

endinterface

// File: rtl/cmos_reg_cfg_ctrl_table.sv
// Synchronous register-table ROM for one sensor. Data appears one clock after
// the address. This ROM is placed beside the sequencer and not inside it.
module cmos_reg_table
    import cmos_cfg_pkg::*;
(
    input  logic               clk,
    input  logic [7:0]         addr_i,
    output logic [ENTRY_W-1:0] data_o
);

    // Registered lookup of the initialisation entries.
    always_ff @(posedge clk) begin
        case (addr_i)
            8'd0:    data_o <= {16'h3008, 8'h82};
            8'd1:    data_o <= {16'h3103, 8'h03};
            8'd2:    data_o <= {16'h3017, 8'hFF};
            8'd3:    data_o <= {16'h3018, 8'hFF};
            8'd4:    data_o <= {DELAY_MARKER, 8'h02};
            8'd5:    data_o <= {16'h3034, 8'h1A};
            default: data_o <= '0;
        endcase
    end

endmodule

// File: rtl/cmos_reg_cfg_ctrl.sv
// Camera register configuration sequencer. After the power-up wait it walks the
// register table, issuing one SCCB byte write per entry. Failed writes are
// retried and delay entries pause the sequence. The done/err flags gate the
// capture path.
module cmos_reg_cfg_ctrl
    import cmos_cfg_pkg::*;
#(
    parameter logic [7:0]  REG_NUM      = 8'd250,
    parameter logic [19:0] POWER_UP_DLY = 20'd1000000,
    parameter logic [7:0]  INTER_GAP    = 8'd100,
    parameter logic [2:0]  MAX_RETRY    = 3'd3,
    parameter logic [15:0] TIMEOUT      = 16'd50000,
    parameter logic [15:0] DLY_UNIT     = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    cmos_reg_cfg_ctrl_if.master bus,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [7:0]          cfg_idx
);

    cfgState_e          state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [2:0]         retry_q, retry_d;
    logic [19:0]        pwrCnt_q, pwrCnt_d;
    logic [7:0]         gapCnt_q, gapCnt_d;
    logic [15:0]        toCnt_q, toCnt_d;
    logic [15:0]        unitCnt_q, unitCnt_d;
    logic [7:0]         dlyCnt_q, dlyCnt_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic               busy_q, done_q, err_q;
    logic               advance, fail;

    // Next-state logic. Counters default to zero, so each one restarts whenever
    // its state is left. A finished entry (write acknowledged or delay elapsed)
    // raises advance; a NACK or timeout raises fail.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        entry_d   = entry_q;
        pwrCnt_d  = '0;
        gapCnt_d  = '0;
        toCnt_d   = '0;
        unitCnt_d = '0;
        dlyCnt_d  = '0;
        advance   = 1'b0;
        fail      = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (pwrCnt_q == POWER_UP_DLY - 20'd1) state_d = FETCH_ADDR;
                else pwrCnt_d = pwrCnt_q + 20'd1;
            end
            FETCH_ADDR: state_d = FETCH_DATA;
            FETCH_DATA: begin
                entry_d = bus.tbl_data;
                if (entryAddr(bus.tbl_data) == DELAY_MARKER) begin
                    if (entryVal(bus.tbl_data) == 8'd0) advance = 1'b1;
                    else state_d = DELAY;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.i2c_done) begin
                    if (bus.i2c_ack_err) fail = 1'b1;
                    else advance = 1'b1;
                end else if (toCnt_q == TIMEOUT - 16'd1) begin
                    fail = 1'b1;
                end else begin
                    toCnt_d = toCnt_q + 16'd1;
                end
            end
            GAP: begin
                if (gapCnt_q == INTER_GAP - 8'd1) state_d = FETCH_ADDR;
                else gapCnt_d = gapCnt_q + 8'd1;
            end
            DELAY: begin
                if (unitCnt_q == DLY_UNIT - 16'd1) begin
                    if (dlyCnt_q == entryVal(entry_q) - 8'd1) advance = 1'b1;
                    else dlyCnt_d = dlyCnt_q + 8'd1;
                end else begin
                    unitCnt_d = unitCnt_q + 16'd1;
                    dlyCnt_d  = dlyCnt_q;
                end
            end
            DONE, ERROR: begin
                if (cfg_start) begin
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = FETCH_ADDR;
                end
            end
            default: state_d = PWR_WAIT;
        endcase

        if (advance) begin
            retry_d = '0;
            if (idx_q == REG_NUM - 8'd1) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 8'd1;
                state_d = GAP;
            end
        end

        if (fail) begin
            retry_d = retry_q + 3'd1;
            state_d = (retry_q + 3'd1 == MAX_RETRY) ? ERROR : GAP;
        end
    end

    // State, counter and entry registers. The status flags are registered from
    // the next state, so they read zero while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PWR_WAIT;
            idx_q     <= '0;
            retry_q   <= '0;
            pwrCnt_q  <= '0;
            gapCnt_q  <= '0;
            toCnt_q   <= '0;
            unitCnt_q <= '0;
            dlyCnt_q  <= '0;
            entry_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            pwrCnt_q  <= pwrCnt_d;
            gapCnt_q  <= gapCnt_d;
            toCnt_q   <= toCnt_d;
            unitCnt_q <= unitCnt_d;
            dlyCnt_q  <= dlyCnt_d;
            entry_q   <= entry_d;
            busy_q    <= (state_d != DONE) && (state_d != ERROR);
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == ERROR);
        end
    end

    assign bus.tbl_addr  = idx_q;
    assign bus.i2c_exec  = (state_q == ISSUE);
    assign bus.i2c_addr  = entryAddr(entry_q);
    assign bus.i2c_wdata = entryVal(entry_q);
    assign cfg_idx       = idx_q;
    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_cmos_reg_cfg_ctrl.sv
// Self-checking bench for cmos_reg_cfg_ctrl. Each scenario loads a table and a
// script of SCCB responses. A timeline model then computes the expected cycle of
// every write and the status outputs from the sequencing rules. The bench
// compares the DUT against that timeline on every cycle.
module tb_cmos_reg_cfg_ctrl;
    import cmos_cfg_pkg::*;

    localparam int NCYC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [7:0]  cfg_idx;
    logic [23:0] romData, benchData;
    bit          useRom;
    logic [23:0] tbl [4];

    int respLat [16];
    bit respNack[16];
    bit respNone[16];
    int execSeen;
    int pendCnt;
    bit pendNack;

    bit          eExec [NCYC];
    bit          eAddrV[NCYC];
    bit          eBusy [NCYC];
    bit          eDone [NCYC];
    bit          eErr  [NCYC];
    logic [15:0] eAddr [NCYC];
    logic [7:0]  eData [NCYC];
    logic [7:0]  eIdx  [NCYC];
    int          endCyc;
    bit          finalDone;
    bit          prevDone, prevErr;
    logic [7:0]  prevIdx;

    int execObs[$];
    int execIdxObs[$];
    int addrObs[$];
    int firstDoneCyc;

    int checks = 0;
    int errors = 0;

    cmos_reg_cfg_ctrl_if bus();

    cmos_reg_cfg_ctrl #(
        .REG_NUM(8'd4), .POWER_UP_DLY(20'd20), .INTER_GAP(8'd3),
        .MAX_RETRY(3'd3), .TIMEOUT(16'd40), .DLY_UNIT(16'd5)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .bus(bus),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_idx(cfg_idx)
    );

    cmos_reg_table rom (.clk(clk), .addr_i(bus.tbl_addr), .data_o(romData));

    always #5 clk = ~clk;

    // Bench-side table with the same one-cycle read latency as the ROM.
    always @(posedge clk) benchData <= tbl[bus.tbl_addr[1:0]];

    assign bus.tbl_data = useRom ? romData : benchData;

    // SCCB responder: answers the n-th write with the n-th scripted response.
    initial begin
        bus.i2c_done = 1'b0;
        bus.i2c_ack_err = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2c_done = 1'b0;
            bus.i2c_ack_err = 1'b0;
            if (rst) pendCnt = 0;
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    bus.i2c_done = 1'b1;
                    bus.i2c_ack_err = pendNack;
                end
            end
            if (bus.i2c_exec === 1'b1 && !rst) begin
                if (!respNone[execSeen]) begin
                    pendCnt = respLat[execSeen];
                    pendNack = respNack[execSeen];
                end
                if (execSeen < 15) execSeen++;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %h expected %h", name, c, act, exp);
        end
    endtask

    function automatic int obsAt(input int i);
        return (i < execObs.size()) ? execObs[i] : -1;
    endfunction

    // Timeline model. An entry fetched from cycle t writes at t+2. The outcome is
    // known from the response script at t+2+latency, or at t+2+40 on timeout.
    // A delay entry ends at t+2+5*val. The following fetch comes 1+3 cycles later.
    task automatic buildModel(input bit fromReset);
        int t, idx, retry, k, e, d, adv;
        bit ok, fin;
        for (int c = 0; c < NCYC; c++) begin
            eExec[c] = 0; eAddrV[c] = 0; eIdx[c] = 8'd0;
            eAddr[c] = 16'd0; eData[c] = 8'd0;
        end
        if (!fromReset) eIdx[0] = prevIdx;
        t = fromReset ? 20 : 1;
        idx = 0; retry = 0; k = 0; fin = 0; adv = 0;
        while (!fin) begin
            if (tbl[idx][23:8] == 16'hFFFF) begin
                adv = t + 2 + int'(tbl[idx][7:0]) * 5;
                ok = 1;
            end else begin
                e = t + 2;
                eExec[e] = 1;
                if (respNone[k] || respLat[k] > 40) begin
                    d = e + 40;
                    ok = 0;
                end else begin
                    d = e + respLat[k];
                    ok = !respNack[k];
                end
                k++;
                for (int c = e; c <= d; c++) begin
                    eAddrV[c] = 1;
                    eAddr[c] = tbl[idx][23:8];
                    eData[c] = tbl[idx][7:0];
                end
                adv = d + 1;
            end
            if (ok) begin
                retry = 0;
                if (idx == 3) begin
                    fin = 1; finalDone = 1;
                end else begin
                    idx++;
                    for (int c = adv; c < NCYC; c++) eIdx[c] = 8'(idx);
                    t = adv + 3;
                end
            end else begin
                retry++;
                if (retry == 3) begin
                    fin = 1; finalDone = 0;
                end else begin
                    t = adv + 3;
                end
            end
        end
        endCyc = adv;
        for (int c = 0; c < NCYC; c++) begin
            eBusy[c] = (c >= 1) && (c < endCyc);
            eDone[c] = (c >= endCyc) && finalDone;
            eErr[c]  = (c >= endCyc) && !finalDone;
        end
        if (!fromReset) begin
            eDone[0] = prevDone;
            eErr[0]  = prevErr;
        end
    endtask

    task automatic checkOutput(input int c);
        checkVal("exec", c, 32'(bus.i2c_exec), 32'(eExec[c]));
        checkVal("busy", c, 32'(cfg_busy), 32'(eBusy[c]));
        checkVal("done", c, 32'(cfg_done), 32'(eDone[c]));
        checkVal("err",  c, 32'(cfg_err),  32'(eErr[c]));
        checkVal("idx",  c, 32'(cfg_idx),  32'(eIdx[c]));
        if (eAddrV[c]) begin
            checkVal("i2cAddr",  c, 32'(bus.i2c_addr),  32'(eAddr[c]));
            checkVal("i2cWdata", c, 32'(bus.i2c_wdata), 32'(eData[c]));
        end
        if (bus.i2c_exec === 1'b1) begin
            execObs.push_back(c);
            execIdxObs.push_back(int'(cfg_idx));
            addrObs.push_back(int'(bus.i2c_addr));
        end
        if (c > 0 && cfg_done === 1'b1 && firstDoneCyc < 0) firstDoneCyc = c;
    endtask

    // Runs one scenario, started either from reset or with cfg_start. A
    // non-negative abortAt asserts reset inside that cycle instead.
    task automatic applyStimulus(input bit fromReset, input int abortAt);
        int pulseCyc;
        execSeen = 0;
        pendCnt = 0;
        execObs.delete();
        execIdxObs.delete();
        addrObs.delete();
        firstDoneCyc = -1;
        buildModel(fromReset);
        pulseCyc = (abortAt < 0) ? int'($urandom_range(2, endCyc - 2)) : -1;
        if (fromReset) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            cfg_start = 1'b1;
        end
        for (int c = 0; c <= endCyc + 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                cfg_start = (c == pulseCyc);
            end
            if (c == abortAt) begin
                #2 rst = 1'b1;
                #1;
                checkVal("rstExec",  c, 32'(bus.i2c_exec), 32'd0);
                checkVal("rstBusy",  c, 32'(cfg_busy), 32'd0);
                checkVal("rstDone",  c, 32'(cfg_done), 32'd0);
                checkVal("rstErr",   c, 32'(cfg_err), 32'd0);
                checkVal("rstIdx",   c, 32'(cfg_idx), 32'd0);
                checkVal("rstAddr",  c, 32'(bus.i2c_addr), 32'd0);
                checkVal("rstWdata", c, 32'(bus.i2c_wdata), 32'd0);
                return;
            end
            #1;
            checkOutput(c);
        end
        prevDone = finalDone;
        prevErr  = !finalDone;
        prevIdx  = eIdx[endCyc];
    endtask

    task automatic setAllAck(input int lat);
        for (int i = 0; i < 16; i++) begin
            respLat[i] = lat; respNack[i] = 0; respNone[i] = 0;
        end
    endtask

    task automatic randomResponses();
        int r;
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(0, 99));
            respNone[i] = (r < 10);
            respLat[i]  = (r < 25) ? int'($urandom_range(38, 45)) : int'($urandom_range(1, 37));
            respNack[i] = ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic randomTable(input bit allowDelay);
        for (int i = 0; i < 4; i++) begin
            if (allowDelay && $urandom_range(0, 3) == 0)
                tbl[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
            else
                tbl[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
        end
    endtask

    int cnt2;

    initial begin
        // Scenario 1: power-up from reset with the ROM, every write acknowledged.
        useRom = 1;
        tbl[0] = {16'h3008, 8'h82};
        tbl[1] = {16'h3103, 8'h03};
        tbl[2] = {16'h3017, 8'hFF};
        tbl[3] = {16'h3018, 8'hFF};
        setAllAck(10);
        applyStimulus(1, -1);
        checkVal("s1FirstExec", 0, 32'(obsAt(0)), 32'd22);
        checkVal("s1ExecCount", 0, 32'(execObs.size()), 32'd4);
        checkVal("s1FirstAddr", 0, (addrObs.size() > 0) ? 32'(addrObs[0]) : 32'hFFFFFFFF, 32'h3008);
        checkVal("s1DoneCycle", 0, 32'(firstDoneCyc), 32'd81);

        // Scenario 2: restart from DONE, entry 1 is a three-unit delay.
        useRom = 0;
        tbl[0] = {16'h3100, 8'h11};
        tbl[1] = {16'hFFFF, 8'h03};
        tbl[2] = {16'h3200, 8'h22};
        tbl[3] = {16'h3300, 8'h33};
        applyStimulus(0, -1);
        checkVal("s2FirstExec",  0, 32'(obsAt(0)), 32'd3);
        checkVal("s2SecondExec", 0, 32'(obsAt(1)), 32'd39);
        checkVal("s2ExecCount",  0, 32'(execObs.size()), 32'd3);

        // Scenario 3: entry 2 is NACKed twice, then acknowledged.
        randomTable(0);
        setAllAck(10);
        respNack[2] = 1;
        respNack[3] = 1; respLat[3] = 7;
        respLat[4] = 12;
        applyStimulus(0, -1);
        cnt2 = 0;
        foreach (execIdxObs[i]) if (execIdxObs[i] == 2) cnt2++;
        checkVal("s3Entry2Execs", 0, 32'(cnt2), 32'd3);
        checkVal("s3FinalErr",  0, 32'(cfg_err), 32'd0);
        checkVal("s3FinalDone", 0, 32'(cfg_done), 32'd1);

        // Scenario 4: entry 0 is never answered.
        randomTable(0);
        setAllAck(10);
        for (int i = 0; i < 3; i++) respNone[i] = 1;
        applyStimulus(0, -1);
        checkVal("s4Exec0", 0, 32'(obsAt(0)), 32'd3);
        checkVal("s4Exec1", 0, 32'(obsAt(1)), 32'd49);
        checkVal("s4Exec2", 0, 32'(obsAt(2)), 32'd95);
        checkVal("s4ExecCount", 0, 32'(execObs.size()), 32'd3);
        checkVal("s4Err",  0, 32'(cfg_err), 32'd1);
        checkVal("s4Idx",  0, 32'(cfg_idx), 32'd0);
        checkVal("s4Busy", 0, 32'(cfg_busy), 32'd0);

        // Scenario 5: random tables and random response scripts.
        for (int n = 0; n < 6; n++) begin
            randomTable(1);
            randomResponses();
            applyStimulus(0, -1);
        end

        // Scenario 6: reset while the first write is outstanding.
        randomTable(0);
        setAllAck(10);
        applyStimulus(1, 25);

        // Scenario 7: full restart after that reset, including the power-up wait.
        randomTable(1);
        tbl[0] = {16'h3A00, 8'h5C};
        randomResponses();
        respNone[0] = 0; respNack[0] = 0; respLat[0] = 10;
        applyStimulus(1, -1);
        checkVal("s7FirstExec", 0, 32'(obsAt(0)), 32'd22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
